t_debounce_pulser: RTL and testbench
====================================

// Module: t_debounce_pulser
// PURPOSE
//   Front-end stage that drives the t input of t_latch / toggle flops.
//   Synchronises a raw mechanical button, debounces it in both directions and emits a
//   one-cycle toggle pulse on each clean press. While the button is held, it optionally
//   auto-repeats the pulse. It also keeps a wrapping count of emitted pulses for debug.
// PARAMETERS
//   DB_CYCLES      4   consecutive stable synchronised samples needed to accept a level change (>=1)
//   REPEAT_CYCLES  16  cycles between auto-repeat pulses while held; 0 disables auto-repeat
//   CNT_W          8   width of internal debounce/repeat counter; must hold max(DB_CYCLES,REPEAT_CYCLES)
// PORTS
//   clk          in   1  single system clock, all logic on rising edge
//   rst_n        in   1  asynchronous, active-low reset
//   btn_in       in   1  raw asynchronous button level, active high
//   en           in   1  1 = pulses may be emitted on t; 0 = t forced low, FSM keeps running
//   t            out  1  registered one-cycle toggle pulse, feeds t_latch.t
//   btn_level    out  1  registered debounced button level
//   pulse_count  out  8  number of pulses emitted on t, wraps 255->0
// BEHAVIOUR
//   Reset (rst_n=0, async): sync flops=0, state=IDLE, counter=0, t=0, btn_level=0, pulse_count=0.
//   Synchroniser: two flops, btn_in -> s1 -> btn_sync. FSM uses only btn_sync.
//   FSM states (registered):
//     IDLE:    btn_sync=1 -> PRESS_WAIT, cnt=1.
//     PRESS_WAIT: btn_sync=0 -> IDLE, cnt=0, no pulse.
//       btn_sync=1 and cnt==DB_CYCLES -> PRESSED, btn_level=1, t=en, cnt=0.
//       else cnt++.
//     PRESSED: btn_sync=0 -> RELEASE_WAIT, cnt=1.
//       REPEAT_CYCLES!=0 and cnt==REPEAT_CYCLES-1 -> t=en, cnt=0.
//       else cnt++.
//     RELEASE_WAIT: btn_sync=1 -> PRESSED, cnt=0, no pulse (bounce on release).
//       btn_sync=0 and cnt==DB_CYCLES -> IDLE, btn_level=0, cnt=0.
//       else cnt++.
//   t is high for exactly one cycle per pulse event and is never high on two consecutive
//   cycles. The only exception is REPEAT_CYCLES=1, where t is high every cycle while held.
//   Press latency: with btn_in stable high from the edge at which it is first sampled (edge 0),
//     btn_sync=1 after edge 1, and t/btn_level rise after edge 2+DB_CYCLES.
//   Release latency: btn_level falls 2+DB_CYCLES edges after btn_in is first sampled low.
//   pulse_count increments only when t is asserted. Suppressed events (en=0) do not count.
//     Wrap-around is 8'hFF -> 8'h00.
//   en is sampled in the same cycle as the pulse event. Toggling en never changes state or cnt.
//   Reset asserted mid-debounce or mid-hold aborts immediately to the reset values.
//     Any pending pulse is lost.
//   Counter saturation is impossible given the CNT_W constraint. Out-of-range parameters
//     are flagged by an elaboration-time check.
// TESTING  (DB_CYCLES=4, REPEAT_CYCLES=16, en=1 unless stated)
//   1. rst_n=0 for 2 cycles, btn_in=1 -> t=0, btn_level=0, pulse_count=0 throughout reset.
//   2. Clean press: btn_in 0->1 held 40 cycles -> t high exactly 1 cycle, 6 edges after first
//      sample. Then auto-repeat pulses every 16 cycles (2 of them). pulse_count=3.
//   3. Bounce: btn_in high 3 cycles, low 1, high 3, low -> no t pulse, btn_level stays 0,
//      pulse_count unchanged.
//   4. Release bounce: held press, then btn_in 1->0 for 2 cycles, back to 1, then 0 for 10
//      -> btn_level stays 1 through the bounce and falls once. No extra t pulse.
//   5. en=0 during a press -> t stays 0, btn_level still rises, pulse_count unchanged.
//      Set en=1 before the next repeat -> that pulse is emitted and counted.
//   6. Preload by 255 presses, then one more press -> pulse_count 8'hFF -> 8'h00.
//      Separately, pulse rst_n low mid-PRESS_WAIT -> outputs immediately 0 and no late pulse.

Source files
------------

// File: rtl/t_debounce_pulser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : t_debounce_pulser                                              |
// | Function : button synchroniser + two-way debouncer, one-cycle toggle      |
// |            pulse per press with optional auto-repeat and a pulse counter  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module t_debounce_pulser #(
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic       en,
    output logic       t,
    output logic       btn_level,
    output logic [7:0] pulse_count
);

    if (CNT_W < 1 || CNT_W > 30 || DB_CYCLES < 1 || DB_CYCLES > (2**CNT_W) - 1 ||
        REPEAT_CYCLES < 0 || REPEAT_CYCLES > (2**CNT_W) - 1) begin : g_bad_params
        $error("t_debounce_pulser: DB_CYCLES/REPEAT_CYCLES out of range for CNT_W");
    end

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_db_cnt   = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] c_rep_last = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
    localparam logic             c_rep_en   = (REPEAT_CYCLES != 0);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic             s1_q;
    logic             sync_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             t_q, t_d;
    logic             level_q, level_d;
    logic [7:0]       count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            t_q     <= 1'b0;
            level_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            s1_q    <= btn_in;
            sync_q  <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = 1'b0;
        level_d = level_q;
        case (state_q)
            S_IDLE: begin
                if (sync_q) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = c_cnt_one;
                end
            end
            S_PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_db_cnt) begin
                    state_d = S_PRESSED;
                    level_d = 1'b1;
                    t_d     = en;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            S_PRESSED: begin
                // With auto-repeat disabled the counter is parked so it cannot wrap.
                if (!sync_q) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = c_cnt_one;
                end else if (c_rep_en && cnt_q == c_rep_last) begin
                    t_d   = en;
                    cnt_d = '0;
                end else if (c_rep_en) begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            S_RELEASE_WAIT: begin
                if (sync_q) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == c_db_cnt) begin
                    state_d = S_IDLE;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        count_d = t_d ? (count_q + 8'd1) : count_q;
    end

    assign t           = t_q;
    assign btn_level   = level_q;
    assign pulse_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_t_debounce_pulser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_t_debounce_pulser                                           |
// | Function : directed self-checking bench for t_debounce_pulser             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_t_debounce_pulser;

    logic       clk;
    logic       rst_n;
    logic       btn_in;
    logic       en;
    logic       t;
    logic       btn_level;
    logic [7:0] pulse_count;

    int checks;
    int errors;
    int pulses;
    logic t_prev;
    logic consec;

    t_debounce_pulser #(
        .DB_CYCLES    (4),
        .REPEAT_CYCLES(16),
        .CNT_W        (8)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .en         (en),
        .t          (t),
        .btn_level  (btn_level),
        .pulse_count(pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts every sampled high cycle of t and flags back-to-back highs.
    initial begin
        pulses = 0;
        t_prev = 1'b0;
        consec = 1'b0;
    end
    always @(negedge clk) begin
        if (t === 1'b1) begin
            pulses <= pulses + 1;
            if (t_prev === 1'b1) consec <= 1'b1;
        end
        t_prev <= t;
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_once();
        btn_in = 1'b1;
        wait_edges(10);
        btn_in = 1'b0;
        wait_edges(10);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        btn_in = 1'b1;
        en     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_edges(1);
            checks++;
            if (t !== 1'b0) begin errors++; $display("FAIL reset_t cyc%0d got %b exp 0", i, t); end
            checks++;
            if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_level cyc%0d got %b exp 0", i, btn_level); end
            checks++;
            if (pulse_count !== 8'd0) begin errors++; $display("FAIL reset_count cyc%0d got %0d exp 0", i, pulse_count); end
        end
        btn_in = 1'b0;
        rst_n  = 1'b1;
        wait_edges(10);
    endtask

    task automatic test_clean_press();
        int p0;
        p0 = pulses;
        btn_in = 1'b1;
        wait_edges(1);
        wait_edges(5);
        checks++;
        if (t !== 1'b0) begin errors++; $display("FAIL press_t_early got %b exp 0", t); end
        checks++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL press_level_early got %b exp 0", btn_level); end
        wait_edges(1);
        checks++;
        if (t !== 1'b1) begin errors++; $display("FAIL press_t_edge6 got %b exp 1", t); end
        checks++;
        if (btn_level !== 1'b1) begin errors++; $display("FAIL press_level_edge6 got %b exp 1", btn_level); end
        checks++;
        if (pulse_count !== 8'd1) begin errors++; $display("FAIL press_count_edge6 got %0d exp 1", pulse_count); end
        wait_edges(1);
        checks++;
        if (t !== 1'b0) begin errors++; $display("FAIL press_t_edge7 got %b exp 0", t); end
        wait_edges(32);
        btn_in = 1'b0;
        wait_edges(20);
        checks++;
        if (pulses - p0 !== 3) begin errors++; $display("FAIL press_pulses got %0d exp 3", pulses - p0); end
        checks++;
        if (pulse_count !== 8'd3) begin errors++; $display("FAIL press_count_end got %0d exp 3", pulse_count); end
        checks++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL press_level_end got %b exp 0", btn_level); end
    endtask

    task automatic test_bounce();
        int p0;
        logic seen_hi;
        p0 = pulses;
        seen_hi = 1'b0;
        for (int r = 0; r < 2; r++) begin
            btn_in = 1'b1;
            for (int i = 0; i < 3; i++) begin wait_edges(1); if (btn_level) seen_hi = 1'b1; end
            btn_in = 1'b0;
            wait_edges(1);
            if (btn_level) seen_hi = 1'b1;
        end
        for (int i = 0; i < 12; i++) begin wait_edges(1); if (btn_level) seen_hi = 1'b1; end
        checks++;
        if (seen_hi !== 1'b0) begin errors++; $display("FAIL bounce_level got %b exp 0", seen_hi); end
        checks++;
        if (pulses - p0 !== 0) begin errors++; $display("FAIL bounce_pulses got %0d exp 0", pulses - p0); end
        checks++;
        if (pulse_count !== 8'd3) begin errors++; $display("FAIL bounce_count got %0d exp 3", pulse_count); end
    endtask

    task automatic test_release_bounce();
        int p0;
        int falls;
        logic found;
        logic prev;
        p0 = pulses;
        found = 1'b0;
        btn_in = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            wait_edges(1);
            if (btn_level) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL relb_press_timeout got %b exp 1", found); end
        btn_in = 1'b0;
        wait_edges(2);
        btn_in = 1'b1;
        wait_edges(3);
        checks++;
        if (btn_level !== 1'b1) begin errors++; $display("FAIL relb_level_hold got %b exp 1", btn_level); end
        btn_in = 1'b0;
        falls = 0;
        prev  = btn_level;
        for (int i = 0; i < 25; i++) begin
            wait_edges(1);
            if (prev && !btn_level) falls++;
            prev = btn_level;
        end
        checks++;
        if (falls !== 1) begin errors++; $display("FAIL relb_falls got %0d exp 1", falls); end
        checks++;
        if (btn_level !== 1'b0) begin errors++; $display("FAIL relb_level_end got %b exp 0", btn_level); end
        checks++;
        if (pulses - p0 !== 1) begin errors++; $display("FAIL relb_pulses got %0d exp 1", pulses - p0); end
        checks++;
        if (pulse_count !== 8'd4) begin errors++; $display("FAIL relb_count got %0d exp 4", pulse_count); end
    endtask

    task automatic test_enable();
        int p0;
        logic found;
        p0 = pulses;
        found = 1'b0;
        en = 1'b0;
        btn_in = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            wait_edges(1);
            if (btn_level) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL en_level_timeout got %b exp 1", found); end
        checks++;
        if (t !== 1'b0) begin errors++; $display("FAIL en_t_suppressed got %b exp 0", t); end
        checks++;
        if (pulse_count !== 8'd4) begin errors++; $display("FAIL en_count_suppressed got %0d exp 4", pulse_count); end
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 25 && !found; i++) begin
            wait_edges(1);
            if (pulse_count !== 8'd4) found = 1'b1;
        end
        checks++;
        if (pulse_count !== 8'd5) begin errors++; $display("FAIL en_repeat_count got %0d exp 5", pulse_count); end
        btn_in = 1'b0;
        wait_edges(12);
        checks++;
        if (pulses - p0 !== 1) begin errors++; $display("FAIL en_pulses got %0d exp 1", pulses - p0); end
    endtask

    task automatic test_wrap_and_reset();
        int p0;
        rst_n = 1'b0;
        btn_in = 1'b0;
        wait_edges(2);
        rst_n = 1'b1;
        wait_edges(3);
        checks++;
        if (pulse_count !== 8'd0) begin errors++; $display("FAIL wrap_start got %0d exp 0", pulse_count); end
        for (int i = 0; i < 255; i++) press_once();
        checks++;
        if (pulse_count !== 8'hFF) begin errors++; $display("FAIL wrap_ff got %0d exp 255", pulse_count); end
        press_once();
        checks++;
        if (pulse_count !== 8'h00) begin errors++; $display("FAIL wrap_00 got %0d exp 0", pulse_count); end
        press_once();
        checks++;
        if (pulse_count !== 8'd1) begin errors++; $display("FAIL wrap_one got %0d exp 1", pulse_count); end
        btn_in = 1'b1;
        wait_edges(4);
        rst_n = 1'b0;
        #1;
        checks++;
        if (pulse_count !== 8'd0 || t !== 1'b0 || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got t=%b lvl=%b cnt=%0d exp all 0", t, btn_level, pulse_count);
        end
        btn_in = 1'b0;
        wait_edges(2);
        rst_n = 1'b1;
        p0 = pulses;
        wait_edges(20);
        checks++;
        if (pulses - p0 !== 0) begin errors++; $display("FAIL midreset_late_pulse got %0d exp 0", pulses - p0); end
        checks++;
        if (pulse_count !== 8'd0 || btn_level !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after got lvl=%b cnt=%0d exp 0/0", btn_level, pulse_count);
        end
        checks++;
        if (consec !== 1'b0) begin errors++; $display("FAIL t_back_to_back got %b exp 0", consec); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        btn_in = 1'b0;
        en     = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_enable();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
